// File: rtl/triangle_bbox_scanner.sv
// Walks the screen-clamped bounding box of a triangle one pixel per handshake, row-major.
// Vertices are signed fixed point (FIX_W bits, FIX_FRAC fraction bits); pixel indices are unsigned.
module triangle_bbox_scanner #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int COORD_BITS = 10,
    parameter int FIX_W      = 32,
    parameter int FIX_FRAC   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [FIX_W-1:0]      i_v1x,
    input  logic [FIX_W-1:0]      i_v1y,
    input  logic [FIX_W-1:0]      i_v2x,
    input  logic [FIX_W-1:0]      i_v2y,
    input  logic [FIX_W-1:0]      i_v3x,
    input  logic [FIX_W-1:0]      i_v3y,
    output logic                  o_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [FIX_W-1:0]      o_x,
    output logic [FIX_W-1:0]      o_y,
    output logic [COORD_BITS-1:0] o_px,
    output logic [COORD_BITS-1:0] o_py,
    output logic                  o_last,
    output logic                  o_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int PAD_BITS = FIX_W - FIX_FRAC - COORD_BITS;

    logic [1:0]            r_state;
    logic [FIX_W-1:0]      r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y;
    logic [COORD_BITS-1:0] r_xmin, r_xmax, r_ymax;
    logic [COORD_BITS-1:0] r_x, r_y;

    int   w_x1, w_y1, w_x2, w_y2, w_x3, w_y3;
    int   w_xmin, w_xmax, w_ymin, w_ymax;
    int   w_xmin_c, w_xmax_c, w_ymin_c, w_ymax_c;
    logic w_empty;
    logic w_hs;
    logic w_x_end;
    logic w_y_end;

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Arithmetic shift floors negative fractional coordinates toward -infinity.
    always_comb begin
        w_x1 = int'($signed(r_v1x) >>> FIX_FRAC);
        w_y1 = int'($signed(r_v1y) >>> FIX_FRAC);
        w_x2 = int'($signed(r_v2x) >>> FIX_FRAC);
        w_y2 = int'($signed(r_v2y) >>> FIX_FRAC);
        w_x3 = int'($signed(r_v3x) >>> FIX_FRAC);
        w_y3 = int'($signed(r_v3y) >>> FIX_FRAC);
        w_xmin = min3(w_x1, w_x2, w_x3);
        w_xmax = max3(w_x1, w_x2, w_x3);
        w_ymin = min3(w_y1, w_y2, w_y3);
        w_ymax = max3(w_y1, w_y2, w_y3);
        w_empty = (w_xmax < 0) || (w_ymax < 0) || (w_xmin >= SCREEN_W) || (w_ymin >= SCREEN_H);
        w_xmin_c = (w_xmin < 0) ? 0 : w_xmin;
        w_ymin_c = (w_ymin < 0) ? 0 : w_ymin;
        w_xmax_c = (w_xmax > SCREEN_W - 1) ? SCREEN_W - 1 : w_xmax;
        w_ymax_c = (w_ymax > SCREEN_H - 1) ? SCREEN_H - 1 : w_ymax;
    end

    assign w_x_end = (r_x == r_xmax);
    assign w_y_end = (r_y == r_ymax);
    assign w_hs    = (r_state == SCAN) && i_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_v1x   <= '0;
            r_v1y   <= '0;
            r_v2x   <= '0;
            r_v2y   <= '0;
            r_v3x   <= '0;
            r_v3y   <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymax  <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_v1x   <= i_v1x;
                        r_v1y   <= i_v1y;
                        r_v2x   <= i_v2x;
                        r_v2y   <= i_v2y;
                        r_v3x   <= i_v3x;
                        r_v3y   <= i_v3y;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_empty) begin
                        r_state <= DONE;
                    end else begin
                        r_xmin  <= COORD_BITS'(w_xmin_c);
                        r_xmax  <= COORD_BITS'(w_xmax_c);
                        r_ymax  <= COORD_BITS'(w_ymax_c);
                        r_x     <= COORD_BITS'(w_xmin_c);
                        r_y     <= COORD_BITS'(w_ymin_c);
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    // End-of-row/box tests precede any increment, so counters never wrap.
                    if (w_hs) begin
                        if (w_x_end) begin
                            if (w_y_end) begin
                                r_state <= DONE;
                            end else begin
                                r_x <= r_xmin;
                                r_y <= r_y + 1'b1;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == IDLE);
    assign o_valid = (r_state == SCAN);
    assign o_done  = (r_state == DONE);
    assign o_last  = (r_state == SCAN) && w_x_end && w_y_end;
    assign o_px    = r_x;
    assign o_py    = r_y;
    assign o_x     = {{PAD_BITS{1'b0}}, r_x, {FIX_FRAC{1'b0}}};
    assign o_y     = {{PAD_BITS{1'b0}}, r_y, {FIX_FRAC{1'b0}}};

endmodule
